axil_mem_arbiter: RTL and testbench
===================================

// Module: axil_mem_arbiter
// PURPOSE
//  2:1 AXI4-Lite arbiter between the core's two memory masters and the single memory slave.
//  Master 0 is the instruction fetch port (read only); master 1 is the load/store port (read/write).
//  Serialises transactions: exactly one outstanding transaction at a time, owned by one master until its response completes.
//  Sits directly downstream of the fetch and load/store units, upstream of the SRAM/bus slave.
// PARAMETERS
//  ADDR_W  32  address width of all AR/AW channels
//  DATA_W  32  data width of R/W channels; wstrb is DATA_W/8
// PORTS
//  clk                                        in   1        core clock
//  rst                                        in   1        asynchronous, active-low reset
//  ifu_araddr / ifu_arvalid / ifu_arready     in/in/out     ADDR_W/1/1  fetch read address
//  ifu_rdata / ifu_rresp / ifu_rvalid / ifu_rready  out/out/out/in  DATA_W/2/1/1  fetch read data
//  lsu_araddr / lsu_arvalid / lsu_arready     in/in/out     ADDR_W/1/1  load address
//  lsu_rdata / lsu_rresp / lsu_rvalid / lsu_rready  out/out/out/in  DATA_W/2/1/1  load data
//  lsu_awaddr / lsu_awvalid / lsu_awready     in/in/out     ADDR_W/1/1  store address
//  lsu_wdata / lsu_wstrb / lsu_wvalid / lsu_wready  in/in/in/out  DATA_W/DATA_W/8/1/1  store data
//  lsu_bresp / lsu_bvalid / lsu_bready        out/out/in    2/1/1       store response
//  m_ar*, m_r*, m_aw*, m_w*, m_b*             mirror        as above    single slave-side AXI4-Lite master port
// BEHAVIOUR
//  Reset: state=IDLE; every *valid/*ready output driven 0; data outputs 0.
//  FSM states: IDLE, IFU_R, LSU_R, LSU_W.
//  IDLE: sample requests; priority lsu_awvalid|lsu_wvalid > lsu_arvalid > ifu_arvalid; go to the winner's state next cycle.
//  No request in IDLE -> stay in IDLE. IDLE drives nothing to the slave: one-cycle arbitration bubble.
//  IFU_R / LSU_R: the owner's AR and R channels are wired combinationally to m_ar*/m_r*.
//  IFU_R / LSU_R exit: return to IDLE on the cycle m_rvalid & owner rready.
//  LSU_W: AW and W are passed through independently; AW and W may complete in either order or the same cycle.
//  LSU_W exit: B is forwarded only after both AW and W have handshaken (tracked by aw_done/w_done flags); return to IDLE on m_bvalid & lsu_bready.
//  Non-owner master: sees arready/awready/wready=0 and rvalid/bvalid=0; its request stays pending (AXI: valid held until ready).
//  Address/data from the owner are not registered; the owner holds them stable per AXI rules.
//  rresp/bresp from the slave (incl. SLVERR/DECERR) are passed through unchanged; the arbiter never generates responses.
//  Simultaneous LSU read+write request in IDLE: write wins; read is served next arbitration.
//  Reset asserted mid-transaction: FSM to IDLE immediately; in-flight transaction abandoned; slave is reset alongside.
//  Throughput: best case 1 transaction per (1 bubble + slave latency + 1) cycles.
// CONFIGURATION
//  Macro AXIL_ARB_ROUND_ROBIN_EN:
//   defined -> fairness between the two masters. A 1-bit last_owner register (reset = IFU) is kept.
//   defined, on IFU-vs-LSU contention -> the master not granted last wins. Within LSU, write still beats read.
//   undefined -> fixed priority as above; the IFU can starve under continuous LSU traffic.
// STRUCTURE
//  Package npc_axi_pkg: typedef enum arb_state_t {IDLE,IFU_R,LSU_R,LSU_W}; localparams RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
//  Sub-module axil_arb_pick: combinational grant selector.
//   Inputs: ifu_req, lsu_rreq, lsu_wreq, last_owner.
//   Outputs: one-hot grant.
//   Contains the macro-dependent logic.
//  Channel muxing and the FSM stay in the top module.
// TESTING
//  Single fetch: ifu_araddr=0x8000_0000, slave rdata=0x0000_0413 after 2 cycles -> ifu_rvalid with 0x0000_0413, rresp=0; lsu sees no rvalid.
//  Store: lsu aw=0x8000_1000, w=0xDEAD_BEEF, wstrb=4'hF, W asserted 3 cycles before AW -> one m_aw and one m_w handshake; lsu_bvalid only after both.
//  Contention: ifu_arvalid and lsu_arvalid rise together.
//   Fixed priority: LSU granted first, IFU second.
//   With AXIL_ARB_ROUND_ROBIN_EN after a prior LSU grant: IFU granted first.
//  Same-cycle LSU read+write plus IFU read -> service order W, R(lsu), R(ifu) under fixed priority.
//  Backpressure: ifu_rready low 5 cycles while m_rvalid=1 -> FSM stays IFU_R; m_rready low; no new grant.
//  Reset mid-LSU_W (after AW, before W): rst low 1 cycle -> all valid/ready outputs 0, state IDLE.
//   After reset: the next ifu_arvalid is granted after the 1-cycle bubble.
//  Slave returns rresp=2'b10 -> ifu_rresp=2'b10 unchanged.

Source files
------------

// File: rtl/npc_axi_pkg.sv
// Shared types and constants for the AXI4-Lite memory arbiter.
package npc_axi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IFU_R = 2'd1,
    LSU_R = 2'd2,
    LSU_W = 2'd3
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // One-hot grant vector layout
  localparam int unsigned GNT_W     = 3;
  localparam int unsigned GNT_IFU_R = 0;
  localparam int unsigned GNT_LSU_R = 1;
  localparam int unsigned GNT_LSU_W = 2;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

endpackage

// File: rtl/axil_arb_pick.sv
// Combinational grant selector for the memory arbiter.
// AXIL_ARB_ROUND_ROBIN_EN selects alternating IFU/LSU fairness instead of fixed LSU priority.
module axil_arb_pick
  import npc_axi_pkg::*;
(
  input  logic             ifu_req,
  input  logic             lsu_rreq,
  input  logic             lsu_wreq,
  input  logic             last_owner,
  output logic [GNT_W-1:0] grant
);

  logic lsu_req;
  logic lsu_first;

  assign lsu_req = lsu_rreq | lsu_wreq;

`ifdef AXIL_ARB_ROUND_ROBIN_EN
  // On contention the master that was not granted last goes first
  assign lsu_first = !ifu_req || (last_owner == OWNER_IFU);
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
  assign lsu_first         = 1'b1;
`endif

  // Within the LSU, a write always beats a read
  always_comb begin
    grant = '0;
    if (lsu_req && lsu_first) begin
      if (lsu_wreq) grant[GNT_LSU_W] = 1'b1;
      else          grant[GNT_LSU_R] = 1'b1;
    end else if (ifu_req) begin
      grant[GNT_IFU_R] = 1'b1;
    end
  end

endmodule

// File: rtl/axil_mem_arbiter.sv
// 2:1 AXI4-Lite arbiter: fetch (read-only) and load/store masters onto one slave, one transaction at a time.
// Define AXIL_ARB_ROUND_ROBIN_EN for IFU/LSU fairness; default is fixed LSU-over-IFU priority.
module axil_mem_arbiter
  import npc_axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // fetch read
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic                ifu_arvalid,
  output logic                ifu_arready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  output logic                ifu_rvalid,
  input  logic                ifu_rready,
  // load/store read
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic                lsu_arvalid,
  output logic                lsu_arready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  output logic                lsu_rvalid,
  input  logic                lsu_rready,
  // load/store write
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic                lsu_awvalid,
  output logic                lsu_awready,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic                lsu_wvalid,
  output logic                lsu_wready,
  output logic [1:0]          lsu_bresp,
  output logic                lsu_bvalid,
  input  logic                lsu_bready,
  // slave side
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready
);

  localparam int unsigned STRB_W = DATA_W / 8;

  arb_state_t       state;
  logic             ar_done;
  logic             aw_done;
  logic             w_done;
  logic             last_owner;
  logic [GNT_W-1:0] grant;

  axil_arb_pick u_pick (
    .ifu_req    (ifu_arvalid),
    .lsu_rreq   (lsu_arvalid),
    .lsu_wreq   (lsu_awvalid | lsu_wvalid),
    .last_owner (last_owner),
    .grant      (grant)
  );

  // Ownership FSM plus per-transaction handshake tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ar_done    <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      last_owner <= OWNER_IFU;
    end else begin
      case (state)
        IDLE: begin
          ar_done <= 1'b0;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (grant[GNT_LSU_W]) begin
            state      <= LSU_W;
            last_owner <= OWNER_LSU;
          end else if (grant[GNT_LSU_R]) begin
            state      <= LSU_R;
            last_owner <= OWNER_LSU;
          end else if (grant[GNT_IFU_R]) begin
            state      <= IFU_R;
            last_owner <= OWNER_IFU;
          end
        end
        IFU_R, LSU_R: begin
          if (m_arvalid && m_arready) ar_done <= 1'b1;
          if (m_rvalid && m_rready)   state   <= IDLE;
        end
        LSU_W: begin
          if (m_awvalid && m_awready) aw_done <= 1'b1;
          if (m_wvalid && m_wready)   w_done  <= 1'b1;
          if (m_bvalid && m_bready)   state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Owner's channels are wired straight through; everyone else sees idle handshakes
  always_comb begin
    m_araddr    = '0;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    m_awaddr    = '0;
    m_awvalid   = 1'b0;
    m_wdata     = '0;
    m_wstrb     = STRB_W'(0);
    m_wvalid    = 1'b0;
    m_bready    = 1'b0;
    ifu_arready = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = RESP_OKAY;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = RESP_OKAY;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bresp   = RESP_OKAY;
    lsu_bvalid  = 1'b0;
    case (state)
      IFU_R: begin
        m_araddr    = ifu_araddr;
        m_arvalid   = ifu_arvalid & ~ar_done;
        ifu_arready = m_arready & ~ar_done;
        ifu_rdata   = m_rdata;
        ifu_rresp   = m_rresp;
        ifu_rvalid  = m_rvalid;
        m_rready    = ifu_rready;
      end
      LSU_R: begin
        m_araddr    = lsu_araddr;
        m_arvalid   = lsu_arvalid & ~ar_done;
        lsu_arready = m_arready & ~ar_done;
        lsu_rdata   = m_rdata;
        lsu_rresp   = m_rresp;
        lsu_rvalid  = m_rvalid;
        m_rready    = lsu_rready;
      end
      LSU_W: begin
        // B is only exposed once both AW and W have been accepted
        m_awaddr    = lsu_awaddr;
        m_awvalid   = lsu_awvalid & ~aw_done;
        lsu_awready = m_awready & ~aw_done;
        m_wdata     = lsu_wdata;
        m_wstrb     = lsu_wstrb;
        m_wvalid    = lsu_wvalid & ~w_done;
        lsu_wready  = m_wready & ~w_done;
        lsu_bresp   = m_bresp;
        lsu_bvalid  = m_bvalid & aw_done & w_done;
        m_bready    = lsu_bready & aw_done & w_done;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axil_mem_arbiter.sv
// Directed bench for axil_mem_arbiter with a behavioural slave and response scoreboards.
// Expected grant orders follow AXIL_ARB_ROUND_ROBIN_EN when it is defined.
module tb_axil_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] ifu_araddr, lsu_araddr, lsu_awaddr, m_araddr, m_awaddr;
  logic ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
  logic [DW-1:0] ifu_rdata, lsu_rdata, lsu_wdata, m_rdata, m_wdata;
  logic [1:0] ifu_rresp, lsu_rresp, lsu_bresp, m_rresp, m_bresp;
  logic [DW/8-1:0] lsu_wstrb, m_wstrb;
  logic m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready;
  logic m_wvalid, m_wready, m_bvalid, m_bready;

  axil_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
    .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  int total = 0;
  int passed = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural slave: 2-cycle read latency, B once both AW and W are taken
  logic [1:0]  slv_rresp, slv_bresp;
  logic        rd_pend, aw_got, w_got;
  logic [1:0]  rd_cnt;
  logic [AW-1:0] rd_addr, last_awaddr;
  logic [DW-1:0] last_wdata;
  logic [DW/8-1:0] last_wstrb;
  int ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
  logic [AW-1:0] order_log[$];

  function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h1357_9BDF);
  endfunction

  assign m_arready = rst & ~rd_pend;
  assign m_awready = rst & ~aw_got;
  assign m_wready  = rst & ~w_got;
  assign m_bvalid  = aw_got & w_got;
  assign m_bresp   = slv_bresp;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend <= 1'b0; rd_cnt <= 2'd0; m_rvalid <= 1'b0; m_rdata <= '0; m_rresp <= 2'b00;
      aw_got <= 1'b0; w_got <= 1'b0; rd_addr <= '0;
    end else begin
      if (m_arvalid && m_arready) begin
        rd_pend <= 1'b1; rd_cnt <= 2'd1; rd_addr <= m_araddr;
        ar_cnt++; order_log.push_back(m_araddr);
      end else if (rd_pend && !m_rvalid) begin
        if (rd_cnt == 2'd0) begin
          m_rvalid <= 1'b1; m_rdata <= slave_data(rd_addr); m_rresp <= slv_rresp;
        end else rd_cnt <= rd_cnt - 2'd1;
      end else if (m_rvalid && m_rready) begin
        m_rvalid <= 1'b0; rd_pend <= 1'b0;
      end
      if (m_awvalid && m_awready) begin
        aw_got <= 1'b1; aw_cnt++; last_awaddr <= m_awaddr; order_log.push_back(m_awaddr);
      end
      if (m_wvalid && m_wready) begin
        w_got <= 1'b1; w_cnt++; last_wdata <= m_wdata; last_wstrb <= m_wstrb;
      end
      if (m_bvalid && m_bready) begin
        aw_got <= 1'b0; w_got <= 1'b0;
      end
    end
  end

  // Monitors
  int lsu_rv_seen = 0;
  int early_b = 0;
  bit aw_hs = 1'b0, w_hs = 1'b0;
  always @(negedge clk) begin
    if (lsu_rvalid) lsu_rv_seen++;
    if (lsu_bvalid && !(aw_hs && w_hs)) early_b++;
  end

  logic [33:0] ifu_exp[$], lsu_exp[$];
  logic [1:0]  b_exp[$];
  logic [1:0]  last_ifu_rresp;

  // Read on IFU (lsu=0) or LSU (lsu=1); bp = cycles to hold rready low after rvalid
  task automatic rd(input bit lsu, input logic [AW-1:0] a, input int bp, output int lat);
    logic [33:0] e, got;
    bit ok;
    int snap;
    string nm;
    nm  = lsu ? "lsu" : "ifu";
    lat = 0;
    if (lsu) begin lsu_exp.push_back({slave_data(a), slv_rresp}); lsu_araddr = a; lsu_arvalid = 1'b1; end
    else     begin ifu_exp.push_back({slave_data(a), slv_rresp}); ifu_araddr = a; ifu_arvalid = 1'b1; end
    ok = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if ((lsu ? lsu_arready : ifu_arready) === 1'b1) begin ok = 1'b1; lat = i; break; end
    end
    chk({nm, "_ar_handshake"}, 64'(ok), 64'd1);
    @(posedge clk); #1;
    if (lsu) lsu_arvalid = 1'b0; else ifu_arvalid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((lsu ? lsu_rvalid : ifu_rvalid) === 1'b1) begin ok = 1'b1; break; end
    end
    chk({nm, "_rvalid_seen"}, 64'(ok), 64'd1);
    snap = ar_cnt;
    for (int i = 0; i < bp; i++) begin
      chk("bp_hold_rvalid_rready_lsuarready", 64'({ifu_rvalid, m_rready, lsu_arready}), 64'(3'b100));
      @(negedge clk);
    end
    if (bp > 0) chk("bp_no_new_ar", 64'(ar_cnt), 64'(snap));
    if (lsu) begin lsu_rready = 1'b1; got = {lsu_rdata, lsu_rresp}; e = (lsu_exp.size() > 0) ? lsu_exp.pop_front() : 'x; end
    else     begin ifu_rready = 1'b1; got = {ifu_rdata, ifu_rresp}; e = (ifu_exp.size() > 0) ? ifu_exp.pop_front() : 'x;
                   last_ifu_rresp = ifu_rresp; end
    chk({nm, "_rdata_rresp"}, 64'(got), 64'(e));
    @(posedge clk); #1;
    if (lsu) lsu_rready = 1'b0; else ifu_rready = 1'b0;
  endtask

  // Store; AW is raised w_lead cycles after W
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s, input int w_lead);
    bit ok_aw, ok_w, ok_b;
    logic [1:0] e;
    b_exp.push_back(slv_bresp);
    aw_hs = 1'b0; w_hs = 1'b0;
    ok_aw = 1'b0; ok_w = 1'b0; ok_b = 1'b0;
    fork
      begin
        lsu_wdata = d; lsu_wstrb = s; lsu_wvalid = 1'b1;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (lsu_wready === 1'b1) begin ok_w = 1'b1; break; end
        end
        @(posedge clk); #1 lsu_wvalid = 1'b0; w_hs = 1'b1;
      end
      begin
        repeat (w_lead) @(posedge clk);
        #1 lsu_awaddr = a; lsu_awvalid = 1'b1;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (lsu_awready === 1'b1) begin ok_aw = 1'b1; break; end
        end
        @(posedge clk); #1 lsu_awvalid = 1'b0; aw_hs = 1'b1;
      end
    join
    chk("lsu_aw_w_handshake", 64'({ok_aw, ok_w}), 64'(2'b11));
    lsu_bready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (lsu_bvalid === 1'b1) begin ok_b = 1'b1; break; end
    end
    e = (b_exp.size() > 0) ? b_exp.pop_front() : 'x;
    chk("lsu_bvalid_bresp", 64'({ok_b, lsu_bresp}), 64'({1'b1, e}));
    @(posedge clk); #1 lsu_bready = 1'b0;
  endtask

  task automatic chk_order(input string tag, input logic [AW-1:0] e0, input logic [AW-1:0] e1,
                           input logic [AW-1:0] e2, input int n);
    logic [AW-1:0] exp_q[3];
    exp_q[0] = e0; exp_q[1] = e1; exp_q[2] = e2;
    chk({tag, "_count"}, 64'(order_log.size()), 64'(n));
    for (int i = 0; i < n && i < order_log.size(); i++)
      chk($sformatf("%s_slot%0d", tag, i), 64'(order_log[i]), 64'(exp_q[i]));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid_ready"}, 64'({ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready,
        lsu_wready, lsu_bvalid, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}), 64'd0);
    chk({tag, "_addr"}, 64'({m_araddr, m_awaddr}), 64'd0);
    chk({tag, "_data"}, 64'({m_wdata, ifu_rdata}), 64'd0);
    chk({tag, "_misc"}, 64'({lsu_rdata, m_wstrb, ifu_rresp, lsu_rresp, lsu_bresp}), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat_i, lat_l, lat_x;
    rst = 1'b0;
    ifu_araddr = '0; ifu_arvalid = 1'b0; ifu_rready = 1'b0;
    lsu_araddr = '0; lsu_arvalid = 1'b0; lsu_rready = 1'b0;
    lsu_awaddr = '0; lsu_awvalid = 1'b0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 1'b0;
    lsu_bready = 1'b0;
    slv_rresp = 2'b00; slv_bresp = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk); #1 rst = 1'b1;

    // Single fetch, granted after the one-cycle bubble
    rd(1'b0, 32'h8000_0000, 0, lat_i);
    chk("fetch_grant_latency", 64'(lat_i), 64'd2);
    chk("fetch_lsu_no_rvalid", 64'(lsu_rv_seen), 64'd0);
    chk("fetch_ar_count", 64'(ar_cnt), 64'd1);

    // Store with W leading AW by 3 cycles
    early_b = 0;
    wr(32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 3);
    chk("store_b_after_both", 64'(early_b), 64'd0);
    chk("store_aw_w_count", 64'({aw_cnt[15:0], w_cnt[15:0]}), 64'({16'd1, 16'd1}));
    chk("store_awaddr", 64'(last_awaddr), 64'h8000_1000);
    chk("store_wdata_wstrb", 64'({last_wdata, last_wstrb}), 64'({32'hDEAD_BEEF, 4'hF}));

    // IFU vs LSU read contention after an LSU grant
    order_log.delete();
    fork
      rd(1'b0, 32'h8000_0100, 0, lat_i);
      rd(1'b1, 32'h8000_2000, 0, lat_l);
    join
`ifdef AXIL_ARB_ROUND_ROBIN_EN
    chk_order("contention", 32'h8000_0100, 32'h8000_2000, '0, 2);
`else
    chk_order("contention", 32'h8000_2000, 32'h8000_0100, '0, 2);
`endif

    // Same-cycle LSU write + LSU read + IFU read
    order_log.delete();
    fork
      wr(32'h8000_3000, 32'h1234_5678, 4'h3, 0);
      rd(1'b1, 32'h8000_4000, 0, lat_l);
      rd(1'b0, 32'h8000_0200, 0, lat_i);
    join
`ifdef AXIL_ARB_ROUND_ROBIN_EN
    chk_order("triple", 32'h8000_0200, 32'h8000_3000, 32'h8000_4000, 3);
`else
    chk_order("triple", 32'h8000_3000, 32'h8000_4000, 32'h8000_0200, 3);
`endif
    chk("triple_wdata_wstrb", 64'({last_wdata, last_wstrb}), 64'({32'h1234_5678, 4'h3}));

    // IFU rready backpressure with a pending LSU read
    order_log.delete();
    fork
      rd(1'b0, 32'h8000_0300, 5, lat_i);
      begin
        repeat (4) @(posedge clk);
        #1 rd(1'b1, 32'h8000_5000, 0, lat_l);
      end
    join
    chk_order("backpressure", 32'h8000_0300, 32'h8000_5000, '0, 2);

    // Slave error response passes through unchanged
    slv_rresp = 2'b10;
    rd(1'b0, 32'h8000_0400, 0, lat_i);
    chk("slverr_passthrough", 64'(last_ifu_rresp), 64'(2'b10));
    slv_rresp = 2'b00;

    // Reset in LSU_W after AW, before W
    lsu_awaddr = 32'h8000_6000; lsu_awvalid = 1'b1;
    lat_x = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (lsu_awready === 1'b1) begin lat_x = 1; break; end
    end
    chk("rst_mid_aw_handshake", 64'(lat_x), 64'd1);
    @(posedge clk); #1 lsu_awvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("mid_reset");
    @(posedge clk); #1 rst = 1'b1;
    rd(1'b0, 32'h8000_0500, 0, lat_i);
    chk("post_reset_grant_latency", 64'(lat_i), 64'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
